// File: rtl/moore_1101.sv
// Moore detector for serial pattern 1-1-0-1; z/out are pure state decodes, valid the cycle after the 4th bit.
// No backpressure: one bit is consumed every clock; reset (active-low, async) clears to S0 immediately.
module moore_1101 #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  output logic [3:0] out,
  output logic       z
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t r_state;
  logic   r_z;

  // r_z is registered alongside the state so it is always exactly (state == S4).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S0;
      r_z     <= 1'b0;
    end else begin
      r_z <= 1'b0;
      case (r_state)
        S0: r_state <= x ? S1 : S0;
        S1: r_state <= x ? S2 : S0;
        S2: r_state <= x ? S2 : S3;
        S3: begin
          if (x) begin
            r_state <= S4;
            r_z     <= 1'b1;
          end else begin
            r_state <= S0;
          end
        end
        S4: begin
          if (!x)          r_state <= S0;
          else if (OVERLAP) r_state <= S2;
          else             r_state <= S1;
        end
        default: r_state <= S0;
      endcase
    end
  end

  assign out = {1'b0, r_state};
  assign z   = r_z;

endmodule

// File: tb/tb_moore_1101.sv
// Bench for moore_1101: one overlapping and one non-overlapping instance share stimulus,
// compared against a pattern-suffix reference model plus directed tables.
module tb_moore_1101;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       x = 1'b0;
  logic [3:0] out_o, out_n;
  logic       z_o, z_n;

  int n_checks = 0;
  int n_errors = 0;

  bit hist_o[$];
  bit hist_n[$];
  bit pat[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  moore_1101 #(.OVERLAP(1'b1)) u_ovl (
    .clk(clk), .reset(reset), .x(x), .out(out_o), .z(z_o)
  );

  moore_1101 #(.OVERLAP(1'b0)) u_novl (
    .clk(clk), .reset(reset), .x(x), .out(out_n), .z(z_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Length of the longest suffix of the history that is a prefix of 1101.
  function automatic int match_len(input bit h[$]);
    for (int k = 4; k >= 1; k--) begin
      if (h.size() >= k) begin
        bit ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (h[h.size() - k + i] != pat[i]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  function automatic void model_clear();
    hist_o.delete();
    hist_n.delete();
  endfunction

  function automatic void model_push(input bit b);
    if (match_len(hist_n) == 4) hist_n.delete();
    hist_o.push_back(b);
    hist_n.push_back(b);
    if (hist_o.size() > 8) void'(hist_o.pop_front());
    if (hist_n.size() > 8) void'(hist_n.pop_front());
  endfunction

  task automatic check_model();
    int eo, en;
    eo = match_len(hist_o);
    en = match_len(hist_n);
    check("ovl_out",  int'(out_o), eo);
    check("ovl_z",    int'(z_o),   (eo == 4) ? 1 : 0);
    check("novl_out", int'(out_n), en);
    check("novl_z",   int'(z_n),   (en == 4) ? 1 : 0);
  endtask

  task automatic step(input bit b);
    x = b;
    @(posedge clk);
    model_push(b);
    #1;
    check_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_o"}, int'(out_o), 0);
    check({tag, "_z_o"},   int'(z_o),   0);
    check({tag, "_out_n"}, int'(out_n), 0);
    check({tag, "_z_n"},   int'(z_n),   0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int xs_ov[17]  = '{1,1,1,0,1,1,0,1,1,1,1,1,0,1,0,1,0};
    int ex_ov[17]  = '{1,2,2,3,4,2,3,4,2,2,2,2,3,4,0,1,0};
    int xs_nov[7]  = '{1,1,0,1,1,0,1};
    int ex_nov[7]  = '{1,2,3,4,1,0,1};
    int xs_hit[4]  = '{1,1,0,1};
    int ex_hit[4]  = '{1,2,3,4};
    int xs_nm[8]   = '{1,0,1,1,1,0,0,1};
    int z_count;

    // Reset hold with x toggling across edges.
    reset = 1'b0;
    #1;
    check_reset_outputs("hold0");
    for (int i = 0; i < 4; i++) begin
      x = ~x;
      @(posedge clk);
      #1;
      check_reset_outputs("hold");
    end
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      check("idle_out", int'(out_o), 0);
    end

    // Basic hit.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(xs_hit[i][0]);
      check("hit_out", int'(out_o), ex_hit[i]);
      check("hit_z",   int'(z_o), (i == 3) ? 1 : 0);
    end

    // Overlapping sequence.
    apply_reset();
    z_count = 0;
    for (int i = 0; i < 17; i++) begin
      step(xs_ov[i][0]);
      check("ovl_tbl", int'(out_o), ex_ov[i]);
      if (z_o) z_count++;
    end
    check("ovl_zcount", z_count, 3);

    // Non-overlapping sequence.
    apply_reset();
    z_count = 0;
    for (int i = 0; i < 7; i++) begin
      step(xs_nov[i][0]);
      check("novl_tbl", int'(out_n), ex_nov[i]);
      if (z_n) z_count++;
    end
    check("novl_zcount", z_count, 1);

    // Near misses.
    apply_reset();
    z_count = 0;
    for (int i = 0; i < 8; i++) begin
      step(xs_nm[i][0]);
      if (z_o || z_n) z_count++;
    end
    check("nm_zcount", z_count, 0);
    check("nm_end", int'(out_o), 1);

    // Asynchronous reset while in S4, between edges.
    apply_reset();
    for (int i = 0; i < 4; i++) step(xs_hit[i][0]);
    check("pre_async_out", int'(out_o), 4);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(xs_hit[i][0]);
      check("rehit_out", int'(out_o), ex_hit[i]);
    end

    // Randomized run with occasional async reset pulses.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_reset_outputs("rnd_rst");
        @(negedge clk);
        reset = 1'b1;
      end
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
